mem_arbiter: RTL and testbench

- Arbitrates between the instruction cache and the data cache for the single shared RAM port. Only one request is in flight at a time.
- Sequences each access with a registered grant FSM. The data cache has priority by default.
- A starvation counter forces an instruction grant after STARVE_MAX consecutive data grants taken while an instruction fetch was pending.
- Sits between both caches and the RAM model/controller.

---
 rtl/mem_arbiter.sv | 103 ++++++++++
 tb/tb_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shared RAM port arbiter between instruction and data caches.
// Data cache has priority; a starvation counter forces an instruction grant.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready
);

  typedef enum logic [1:0] {IDLE, DSERV, ISERV} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       d_req;
  logic       starve_hit;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    iwait        = 1'b1;
    dwait        = 1'b1;
    iload        = '0;
    dload        = '0;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    d_req        = dREN | dWEN;
    starve_hit   = iREN && (starve_cnt_q == STARVE_LIM);

    case (state_q)
      IDLE: begin
        // One grant per IDLE visit; strobes stay low here (grant bubble).
        if (d_req && !starve_hit) begin
          state_d = DSERV;
          if (!iREN)
            starve_cnt_d = '0;
          else if (starve_cnt_q != STARVE_LIM)
            starve_cnt_d = starve_cnt_q + 4'd1;
        end else if (iREN) begin
          state_d      = ISERV;
          starve_cnt_d = '0;
        end
      end
      DSERV: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!d_req) begin
          state_d = IDLE;
        end else if (ram_ready) begin
          dwait   = 1'b0;
          dload   = dWEN ? '0 : ramload;
          state_d = IDLE;
        end
      end
      ISERV: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (!iREN) begin
          state_d = IDLE;
        end else if (ram_ready) begin
          iwait   = 1'b0;
          iload   = ramload;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic, all checked cycle by cycle against a transaction-level model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0, ram_ready = 1'b0;
  logic [AW-1:0] iaddr = '0, daddr = '0;
  logic [DW-1:0] dstore = '0, ramload = '0;
  logic          iwait, dwait, ramREN, ramWEN;
  logic [DW-1:0] iload, dload, ramstore;
  logic [AW-1:0] ramaddr;

  int total = 0;
  int bad   = 0;

  // Model: who currently owns the RAM port (0 nobody, 1 dcache, 2 icache)
  // and how many data grants in a row were taken over a waiting fetch.
  int          m_owner  = 0;
  int unsigned m_starve = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected port outputs given the current owner and live inputs.
  task automatic model_check();
    logic          e_iw = 1'b1, e_dw = 1'b1, e_rr = 1'b0, e_rw = 1'b0;
    logic [AW-1:0] e_ad = '0;
    logic [DW-1:0] e_st = '0, e_il = '0, e_dl = '0;
    if (nRST && m_owner == 1) begin
      e_ad = daddr;
      e_st = dstore;
      e_rw = dWEN;
      e_rr = dREN && !dWEN;
      if ((dREN || dWEN) && ram_ready) begin
        e_dw = 1'b0;
        e_dl = dWEN ? '0 : ramload;
      end
    end else if (nRST && m_owner == 2) begin
      e_ad = iaddr;
      e_rr = iREN;
      if (iREN && ram_ready) begin
        e_iw = 1'b0;
        e_il = ramload;
      end
    end
    chk("iwait", 64'(iwait), 64'(e_iw));
    chk("dwait", 64'(dwait), 64'(e_dw));
    chk("ramREN", 64'(ramREN), 64'(e_rr));
    chk("ramWEN", 64'(ramWEN), 64'(e_rw));
    chk("ramaddr", 64'(ramaddr), 64'(e_ad));
    chk("ramstore", 64'(ramstore), 64'(e_st));
    chk("iload", 64'(iload), 64'(e_il));
    chk("dload", 64'(dload), 64'(e_dl));
  endtask

  // Ownership changes at the clock edge, from the inputs held before it.
  task automatic model_edge();
    if (!nRST) begin
      m_owner  = 0;
      m_starve = 0;
    end else if (m_owner == 0) begin
      if ((dREN || dWEN) && !(iREN && m_starve == SM)) begin
        m_owner  = 1;
        m_starve = iREN ? ((m_starve < SM) ? m_starve + 1 : SM) : 0;
      end else if (iREN) begin
        m_owner  = 2;
        m_starve = 0;
      end
    end else begin
      // Any serviced cycle ends ownership if the access finished or was dropped.
      if (m_owner == 1 && (dREN || dWEN) && !ram_ready) m_owner = 1;
      else if (m_owner == 2 && iREN && !ram_ready) m_owner = 2;
      else m_owner = 0;
    end
  endtask

  // Check current inputs, then advance one clock; returns at posedge+2.
  task automatic cyc();
    #1 model_check();
    @(posedge CLK);
    model_edge();
    #2;
  endtask

  task automatic clear_inputs();
    iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
  endtask

  task automatic do_reset();
    nRST = 0;
    m_owner = 0; m_starve = 0;
    cyc();
    cyc();
    nRST = 1;
  endtask

  logic [9:0] grants;
  int         ngrant, nidle;

  initial begin
    @(posedge CLK); #2;

    // Reset with active requests present: port must look idle.
    iREN = 1; dREN = 1; dWEN = 1; ram_ready = 1; iaddr = 32'h55; daddr = 32'h66;
    dstore = 32'h77; ramload = 32'h88;
    #1;
    chk("rst_ramREN", 64'(ramREN), 64'd0);
    chk("rst_ramWEN", 64'(ramWEN), 64'd0);
    chk("rst_waits", {62'd0, iwait, dwait}, 64'd3);
    chk("rst_bus", 64'(ramaddr | ramstore | iload | dload), 64'd0);
    clear_inputs();
    do_reset();

    // Instruction read, single-cycle RAM.
    iREN = 1; iaddr = 32'h40; ram_ready = 1; ramload = 32'hDEADBEEF;
    cyc();
    #1;
    chk("i_rd_ramREN", 64'(ramREN), 64'd1);
    chk("i_rd_addr", 64'(ramaddr), 64'h40);
    chk("i_rd_iwait", 64'(iwait), 64'd0);
    chk("i_rd_iload", 64'(iload), 64'hDEADBEEF);
    cyc();
    iREN = 0;
    #1 chk("i_rd_idle", 64'(ramREN), 64'd0);
    cyc();

    // Data write with three wait cycles.
    dWEN = 1; daddr = 32'h100; dstore = 32'h12345678; ram_ready = 0; ramload = 32'hCAFEF00D;
    cyc();
    for (int k = 0; k < 4; k++) begin
      ram_ready = (k == 3);
      #1;
      chk("wr_ramWEN", 64'(ramWEN), 64'd1);
      chk("wr_addr", 64'(ramaddr), 64'h100);
      chk("wr_dwait", 64'(dwait), (k == 3) ? 64'd0 : 64'd1);
      chk("wr_dload", 64'(dload), 64'd0);
      cyc();
    end
    dWEN = 0;
    cyc();

    // Read and write both set behaves as a write.
    dREN = 1; dWEN = 1; ram_ready = 1; daddr = 32'h200; dstore = 32'hA5A5A5A5;
    cyc();
    #1;
    chk("rw_ramWEN", 64'(ramWEN), 64'd1);
    chk("rw_ramREN", 64'(ramREN), 64'd0);
    chk("rw_dwait", 64'(dwait), 64'd0);
    chk("rw_dload", 64'(dload), 64'd0);
    cyc();
    dREN = 0; dWEN = 0;
    cyc();

    // Continuous contention: expect D,D,D,D,I repeating, IDLE between grants.
    do_reset();
    iREN = 1; dREN = 1; ram_ready = 1; ramload = 32'h1;
    grants = '0; ngrant = 0; nidle = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!iwait && ngrant < 10) begin grants[ngrant] = 1'b1; ngrant++; end
      else if (!dwait && ngrant < 10) ngrant++;
      else if (iwait && dwait) nidle++;
      cyc();
    end
    chk("starve_seq", 64'(grants), 64'h210);
    chk("starve_ngrant", 64'(ngrant), 64'd10);
    chk("starve_idle", 64'(nidle), 64'd10);
    iREN = 0; dREN = 0;
    cyc();

    // Fetch dropped mid-service, then a normal data read.
    iREN = 1; iaddr = 32'h80; ram_ready = 0;
    cyc();
    cyc();
    iREN = 0;
    #1;
    chk("drop_ramREN", 64'(ramREN), 64'd0);
    chk("drop_iwait", 64'(iwait), 64'd1);
    cyc();
    dREN = 1; daddr = 32'h300; ram_ready = 1; ramload = 32'h0BADBEEF;
    cyc();
    #1;
    chk("after_drop_dwait", 64'(dwait), 64'd0);
    chk("after_drop_dload", 64'(dload), 64'h0BADBEEF);
    cyc();
    dREN = 0;
    cyc();

    // Reset pulse in the middle of a data access.
    dREN = 1; daddr = 32'h400; ram_ready = 0;
    cyc();
    cyc();
    nRST = 0; ram_ready = 1;
    m_owner = 0; m_starve = 0;
    #1;
    chk("midrst_ramREN", 64'(ramREN), 64'd0);
    chk("midrst_dwait", 64'(dwait), 64'd1);
    chk("midrst_addr", 64'(ramaddr), 64'd0);
    cyc();
    nRST = 1; dREN = 0;
    cyc();

    // Randomized traffic; requests usually held, sometimes dropped.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        iREN = 1'($urandom); iaddr = $urandom;
      end
      if ($urandom_range(0, 7) == 0) begin
        dREN = 1'($urandom); dWEN = ($urandom_range(0, 3) == 0);
        daddr = $urandom; dstore = $urandom;
      end
      ram_ready = 1'($urandom);
      ramload = $urandom;
      if ($urandom_range(0, 299) == 0) begin
        nRST = 0;
        m_owner = 0; m_starve = 0;
      end else begin
        nRST = 1;
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
